// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB encodings and arbiter state for the bus arbiter slice.
package ahb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ARB_PARK   = 2'b00,
    ARB_OWNED  = 2'b01,
    ARB_BURST  = 2'b10,
    ARB_LOCKED = 2'b11
  } arb_state_e;

  localparam int unsigned BEAT_CNT_W = 5;

  // Beats in a burst; undefined-length INCR counts as one so it never holds the counter.
  function automatic logic [BEAT_CNT_W-1:0] burst_beats(input hburst_e burst);
    case (burst)
      BURST_WRAP4,  BURST_INCR4:  burst_beats = 5'd4;
      BURST_WRAP8,  BURST_INCR8:  burst_beats = 5'd8;
      BURST_WRAP16, BURST_INCR16: burst_beats = 5'd16;
      default:                    burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Request/grant bundle between the masters' side and the arbiter.
interface ahb_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4
);
  import ahb_bus_arbiter_pkg::*;

  localparam int unsigned MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  htrans_e                htrans;
  hburst_e                hburst;
  logic                   hready;
  hresp_e                 hresp;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MIDX_W-1:0]      hmaster;
  logic [MIDX_W-1:0]      hmaster_data;
  logic                   hmastlock;

  // Requester side: drives requests and the muxed address-phase controls.
  modport master (
    output hbusreq, hlock, htrans, hburst, hready, hresp,
    input  hgrant, hmaster, hmaster_data, hmastlock
  );

  // Arbiter side.
  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready, hresp,
    output hgrant, hmaster, hmaster_data, hmastlock
  );

endinterface

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: scans from last+1, wrapping, with last checked last.
module ahb_rr_priority_picker #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MIDX_W      = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MIDX_W-1:0]      last,
  output logic [NUM_MASTERS-1:0] win_oh,
  output logic [MIDX_W-1:0]      win_idx,
  output logic                   valid
);

  int unsigned       cand;
  logic [MIDX_W-1:0] cand_idx;

  always_comb begin
    win_oh   = '0;
    win_idx  = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = 32'(last) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      cand_idx = MIDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid   = 1'b1;
        win_idx = cand_idx;
        win_oh  = NUM_MASTERS'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with fixed-burst and locked-sequence hold, parking on a default master.
module ahb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input logic              hclk,
  input logic              hresetn,
  ahb_bus_arbiter_if.slave bus
);
  import ahb_bus_arbiter_pkg::*;

  localparam int unsigned MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MIDX_W-1:0]      DEF_IDX = MIDX_W'(DEFAULT_MASTER);

  arb_state_e             state_q, state_d;
  logic [BEAT_CNT_W-1:0]  cnt_q, cnt_d, cnt_upd;
  logic                   err_q, err_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MIDX_W-1:0]      hmaster_q, hmaster_d;
  logic [MIDX_W-1:0]      hmaster_data_q, hmaster_data_d;
  logic                   hmastlock_q, hmastlock_d;

  logic                   owner_lock, owner_req, xfer_done;
  logic                   normal_pt, err_pt, arb_point;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [MIDX_W-1:0]      pick_idx;
  logic                   pick_valid;

  ahb_rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .MIDX_W      (MIDX_W)
  ) u_picker (
    .req     (bus.hbusreq),
    .last    (hmaster_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q        <= ARB_PARK;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      hgrant_q       <= DEF_GNT;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hmastlock_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      hgrant_q       <= hgrant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hmastlock_q    <= hmastlock_d;
    end
  end

  // Next state: beat counter, error tracking and arbitration decision.
  always_comb begin
    cnt_upd    = cnt_q;
    err_d      = err_q;
    owner_lock = bus.hlock[hmaster_q];
    owner_req  = bus.hbusreq[hmaster_q];

    if (!bus.hready) begin
      if (bus.hresp == RESP_ERROR) begin
        cnt_upd = '0;
        err_d   = 1'b1;
      end
    end else begin
      err_d = 1'b0;
      case (bus.htrans)
        TRANS_NONSEQ: cnt_upd = burst_beats(bus.hburst) - 5'd1;
        TRANS_SEQ:    cnt_upd = (cnt_q == '0) ? '0 : cnt_q - 5'd1;
        default:      cnt_upd = cnt_q;
      endcase
    end

    // INCR is only released once its owner stops requesting.
    xfer_done = ((bus.htrans == TRANS_NONSEQ) || (bus.htrans == TRANS_SEQ)) &&
                ((bus.hburst != BURST_INCR) || !owner_req);
    normal_pt = bus.hready && (cnt_upd == '0) && !owner_lock &&
                ((bus.htrans == TRANS_IDLE) || xfer_done);
    err_pt    = bus.hready && err_q && !owner_lock;
    arb_point = normal_pt || err_pt;
    cnt_d     = err_pt ? '0 : cnt_upd;

    state_d = state_q;
    if (arb_point) begin
      if (!pick_valid)               state_d = ARB_PARK;
      else if (bus.hlock[pick_idx])  state_d = ARB_LOCKED;
      else                           state_d = ARB_OWNED;
    end else if (bus.hready) begin
      if (owner_lock)                state_d = ARB_LOCKED;
      else if (cnt_d != '0)          state_d = ARB_BURST;
      else if (state_q != ARB_PARK)  state_d = ARB_OWNED;
    end
  end

  // Outputs: grant/owner move only at arbitration points, data owner follows on accepted beats.
  always_comb begin
    hgrant_d       = hgrant_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    hmastlock_d    = hmastlock_q;

    if (arb_point) begin
      if (state_d == ARB_PARK) begin
        hgrant_d  = DEF_GNT;
        hmaster_d = DEF_IDX;
      end else begin
        hgrant_d  = pick_oh;
        hmaster_d = pick_idx;
      end
    end

    if (bus.hready) begin
      hmaster_data_d = hmaster_q;
      hmastlock_d    = owner_lock && (bus.htrans != TRANS_IDLE);
    end
  end

  assign bus.hgrant       = hgrant_q;
  assign bus.hmaster      = hmaster_q;
  assign bus.hmaster_data = hmaster_data_q;
  assign bus.hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scoreboard bench for ahb_bus_arbiter with four masters parking on master 0.
module tb_ahb_bus_arbiter;
  import ahb_bus_arbiter_pkg::*;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] mst;
    logic [1:0] dat;
    logic       lk;
  } exp_t;

  logic hclk;
  logic hresetn;
  int   checks;
  int   errors;
  exp_t sb[$];
  int unsigned exp_m;
  int unsigned exp_d;
  logic        exp_lk;

  ahb_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input htrans_e tr,
                       input hburst_e bu, input logic rdy, input hresp_e rsp);
    bus.hbusreq = req;
    bus.hlock   = lock;
    bus.htrans  = tr;
    bus.hburst  = bu;
    bus.hready  = rdy;
    bus.hresp   = rsp;
  endtask

  // One bus cycle: push what the outputs must show after the edge, then pop and compare.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lock,
                      input htrans_e tr, input hburst_e bu, input logic rdy, input hresp_e rsp,
                      input int unsigned em);
    exp_t e;
    exp_t got;
    drive(req, lock, tr, bu, rdy, rsp);
    if (rdy) begin
      exp_d  = exp_m;
      exp_lk = lock[exp_m[1:0]] && (tr != TRANS_IDLE);
    end
    exp_m   = em;
    e.gnt   = 4'(1) << em;
    e.mst   = 2'(exp_m);
    e.dat   = 2'(exp_d);
    e.lk    = exp_lk;
    sb.push_back(e);
    @(posedge hclk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      got = sb.pop_front();
      chk({tag, "/hgrant"},       32'(bus.hgrant),       32'(got.gnt));
      chk({tag, "/hmaster"},      32'(bus.hmaster),      32'(got.mst));
      chk({tag, "/hmaster_data"}, 32'(bus.hmaster_data), 32'(got.dat));
      chk({tag, "/hmastlock"},    32'(bus.hmastlock),    32'(got.lk));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/hgrant"},       32'(bus.hgrant),       32'h1);
    chk({tag, "/hmaster"},      32'(bus.hmaster),      32'h0);
    chk({tag, "/hmaster_data"}, 32'(bus.hmaster_data), 32'h0);
    chk({tag, "/hmastlock"},    32'(bus.hmastlock),    32'h0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_m   = 0;
    exp_d   = 0;
    exp_lk  = 1'b0;
    hresetn = 1'b0;
    drive(4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY);
    repeat (2) @(posedge hclk);
    #1;
    chk_reset("reset");
    hresetn = 1'b1;

    // Idle: parked on master 0.
    for (int i = 0; i < 5; i++)
      step("idle", 4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY, 0);

    // M1 and M3 request; M1 runs INCR4, then M3 takes over.
    step("m1m3_arb",  4'b1010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 1);
    step("incr4_b1",  4'b1010, 4'b0000, TRANS_NONSEQ, BURST_INCR4,  1'b1, RESP_OKAY, 1);
    step("incr4_b2",  4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1'b1, RESP_OKAY, 1);
    step("incr4_b3",  4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1'b1, RESP_OKAY, 1);
    step("incr4_b4",  4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1'b1, RESP_OKAY, 3);
    step("m3_single", 4'b0100, 4'b0000, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 2);

    // M2 INCR8 with two wait states on beat 5; M0/M1 waiting, then wrap to M0.
    step("incr8_b1",  4'b0111, 4'b0000, TRANS_NONSEQ, BURST_INCR8,  1'b1, RESP_OKAY, 2);
    step("incr8_b2",  4'b0111, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, RESP_OKAY, 2);
    step("incr8_b3",  4'b0111, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, RESP_OKAY, 2);
    step("incr8_b4",  4'b0111, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, RESP_OKAY, 2);
    step("incr8_w1",  4'b0111, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b0, RESP_OKAY, 2);
    step("incr8_w2",  4'b0111, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b0, RESP_OKAY, 2);
    step("incr8_b5",  4'b0111, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, RESP_OKAY, 2);
    step("incr8_b6",  4'b0111, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, RESP_OKAY, 2);
    step("incr8_b7",  4'b0111, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, RESP_OKAY, 2);
    step("incr8_b8",  4'b0111, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1'b1, RESP_OKAY, 0);

    // M1 locked across two SINGLEs while M2 waits.
    step("lock_arb",  4'b0110, 4'b0010, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 1);
    step("lock_s1",   4'b0110, 4'b0010, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 1);
    step("lock_s2",   4'b0110, 4'b0010, TRANS_NONSEQ, BURST_SINGLE, 1'b1, RESP_OKAY, 1);
    step("lock_idle", 4'b0110, 4'b0010, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 1);
    step("lock_rel",  4'b0100, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 2);

    // M3 WRAP16 hit by ERROR on beat 6; M0 takes over at the second ERROR cycle.
    step("wrap16_arb", 4'b1001, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 3);
    step("wrap16_b1",  4'b1001, 4'b0000, TRANS_NONSEQ, BURST_WRAP16, 1'b1, RESP_OKAY, 3);
    for (int i = 0; i < 4; i++)
      step("wrap16_seq", 4'b1001, 4'b0000, TRANS_SEQ,  BURST_WRAP16, 1'b1, RESP_OKAY, 3);
    step("err_c1",     4'b1001, 4'b0000, TRANS_SEQ,    BURST_WRAP16, 1'b0, RESP_ERROR, 3);
    step("err_c2",     4'b1001, 4'b0000, TRANS_IDLE,   BURST_WRAP16, 1'b1, RESP_ERROR, 0);

    // INCR holds while requested, parks when all requests drop.
    step("incr_arb",  4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 1);
    step("incr_b1",   4'b0010, 4'b0000, TRANS_NONSEQ, BURST_INCR,   1'b1, RESP_OKAY, 1);
    step("incr_b2",   4'b0010, 4'b0000, TRANS_SEQ,    BURST_INCR,   1'b1, RESP_OKAY, 1);
    step("park",      4'b0000, 4'b0000, TRANS_IDLE,   BURST_INCR,   1'b1, RESP_OKAY, 0);

    // Asynchronous reset in the middle of an M2 INCR4.
    step("rst_arb",   4'b0100, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 2);
    step("rst_b1",    4'b0100, 4'b0000, TRANS_NONSEQ, BURST_INCR4,  1'b1, RESP_OKAY, 2);
    step("rst_b2",    4'b0100, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1'b1, RESP_OKAY, 2);
    #3;
    hresetn = 1'b0;
    #1;
    chk_reset("async_rst");
    @(posedge hclk);
    #1;
    chk_reset("rst_hold");
    drive(4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY);
    hresetn = 1'b1;
    sb.delete();
    exp_m  = 0;
    exp_d  = 0;
    exp_lk = 1'b0;
    step("post_rst",  4'b0000, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 0);
    step("post_req",  4'b1000, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1'b1, RESP_OKAY, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
